// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Bundles the fetch stage's bus-level signals:
//     - the instruction-memory req/ack channel,
//     - the valid/ready channel toward the decoder,
//     - the PC redirect input from branch/jump resolution.
//   Modports:
//     master - the fetch unit (drives imem_req/imem_addr and the instr_* outputs)
//     slave  - the environment (memory, decoder and redirect source)
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage of the single-issue MIPS core. It holds the PC and fetches one
//   word at a time from instruction memory. Each word goes to the decoder over a
//   valid/ready handshake. Branch/jump redirects replace the PC. A redirect
//   that arrives while a memory request is outstanding lets that request finish
//   and throws its data away.
// Ports:
//   clk         - rising-edge clock
//   reset       - synchronous, active-high reset
//   bus         - instr_fetch_unit_if.master (imem req/ack, instr valid/ready,
//                 redirect)
//   fetch_count - 16-bit wrapping count of instructions accepted by the decoder
// Parameters:
//   RESET_PC    - PC loaded on reset (word aligned)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_unit_if.master     bus,
  output logic [15:0]            fetch_count
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [31:0] pc;
  logic [31:0] nextPc;
  logic        nextReq;
  logic [31:0] nextAddr;
  logic        nextValid;
  logic [31:0] nextInstr;
  logic [31:0] nextInstrPc;
  logic [15:0] nextCount;

  logic        ack;
  logic        redir;
  logic        handshake;
  logic [31:0] target;
  logic [31:0] pcPlus4;
  logic [1:0]  unusedLowBits;

  // An ack is only meaningful while a request is actually outstanding.
  assign ack           = bus.imem_req & bus.imem_ack;
  assign redir         = bus.redirect_valid;
  assign handshake     = bus.instr_valid & bus.instr_ready;
  assign target        = {bus.redirect_pc[31:2], 2'b00};
  assign pcPlus4       = pc + 32'd4;
  assign unusedLowBits = bus.redirect_pc[1:0];

  // State and every registered output update together on the clock edge.
  // Reset wins over everything, including a request still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= 32'h0;
      bus.instr_valid <= 1'b0;
      bus.instr       <= 32'h0;
      bus.instr_pc    <= 32'h0;
      fetch_count     <= 16'h0;
    end else begin
      state           <= nextState;
      pc              <= nextPc;
      bus.imem_req    <= nextReq;
      bus.imem_addr   <= nextAddr;
      bus.instr_valid <= nextValid;
      bus.instr       <= nextInstr;
      bus.instr_pc    <= nextInstrPc;
      fetch_count     <= nextCount;
    end
  end

  // Next-state selection. A redirect in FETCH goes to DISCARD only if a
  // request is outstanding and not yet acked. A redirect in HOLD always
  // goes back to FETCH and takes priority over the decoder handshake.
  always_comb begin
    nextState = state;
    case (state)
      FETCH: begin
        if (redir) begin
          if (bus.imem_req && !ack) nextState = DISCARD;
        end else if (ack) begin
          nextState = HOLD;
        end
      end
      HOLD: begin
        if (redir || handshake) nextState = FETCH;
      end
      DISCARD: begin
        if (ack) nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  // Next values of the registered outputs and the PC.
  // On an ack, imem_addr moves on to the next PC while imem_req drops.
  // This means the decoder handshake only has to raise imem_req again.
  // During DISCARD the old address stays on the bus until the memory acks,
  // because a request cannot be withdrawn.
  always_comb begin
    nextPc      = pc;
    nextReq     = bus.imem_req;
    nextAddr    = bus.imem_addr;
    nextValid   = bus.instr_valid;
    nextInstr   = bus.instr;
    nextInstrPc = bus.instr_pc;
    nextCount   = fetch_count;
    case (state)
      FETCH: begin
        if (redir) begin
          nextPc = target;
          if (ack || !bus.imem_req) begin
            nextReq  = 1'b1;
            nextAddr = target;
          end
        end else if (ack) begin
          nextInstr   = bus.imem_rdata;
          nextInstrPc = pc;
          nextValid   = 1'b1;
          nextPc      = pcPlus4;
          nextReq     = 1'b0;
          nextAddr    = pcPlus4;
        end else begin
          nextReq  = 1'b1;
          nextAddr = pc;
        end
      end
      HOLD: begin
        if (redir) begin
          nextValid = 1'b0;
          nextPc    = target;
          nextReq   = 1'b1;
          nextAddr  = target;
        end else if (handshake) begin
          nextValid = 1'b0;
          nextCount = fetch_count + 16'd1;
          nextReq   = 1'b1;
          nextAddr  = pc;
        end
      end
      DISCARD: begin
        if (redir) nextPc = target;
        if (ack) begin
          nextReq  = 1'b1;
          nextAddr = redir ? target : pc;
        end
      end
      default: begin
        nextValid = 1'b0;
        nextReq   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit.
//   u0 uses RESET_PC=0x00400000 and covers the main fetch, stall, redirect
//   and reset scenarios. u1 uses RESET_PC=0xFFFFFFFC and covers a redirect
//   that coincides with an ack, plus PC wrap-around.
//   Memory data is addr ^ 0xA5A5A5A5. Expected words are pushed on ack and
//   popped at the decoder handshake.
module tb_instr_fetch_unit;

  localparam logic [31:0] PATTERN = 32'hA5A5_A5A5;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } expT;

  logic        clk;
  logic        reset0;
  logic        reset1;
  logic [15:0] fetchCount0;
  logic [15:0] fetchCount1;
  int          checks;
  int          failures;
  int          expCount;
  expT         sb[$];

  instr_fetch_unit_if bi0 ();
  instr_fetch_unit_if bi1 ();

  instr_fetch_unit #(.RESET_PC(32'h0040_0000)) u0 (
    .clk         (clk),
    .reset       (reset0),
    .bus         (bi0),
    .fetch_count (fetchCount0)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk         (clk),
    .reset       (reset1),
    .bus         (bi1),
    .fetch_count (fetchCount1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on u0, clock it, then return inputs to idle.
  task automatic applyStimulus(input logic ack, input logic redir,
                               input logic [31:0] redirPc, input logic ready);
    bi0.imem_ack       = ack;
    bi0.imem_rdata     = ack ? (bi0.imem_addr ^ PATTERN) : 32'h0;
    bi0.redirect_valid = redir;
    bi0.redirect_pc    = redirPc;
    bi0.instr_ready    = ready;
    tick();
    bi0.imem_ack       = 1'b0;
    bi0.imem_rdata     = 32'h0;
    bi0.redirect_valid = 1'b0;
    bi0.redirect_pc    = 32'h0;
    bi0.instr_ready    = 1'b0;
  endtask

  task automatic waitReq();
    int n = 0;
    while (bi0.imem_req !== 1'b1 && n < 20) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    checkOutput("req_seen", {31'h0, bi0.imem_req}, 32'h1);
  endtask

  // Answer one request after waitCycles idle cycles, checking the address.
  task automatic serveFetch(input int waitCycles, input logic [31:0] expAddr);
    expT e;
    waitReq();
    checkOutput("imem_addr", bi0.imem_addr, expAddr);
    for (int i = 0; i < waitCycles; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("req_held", {31'h0, bi0.imem_req}, 32'h1);
      checkOutput("addr_stable", bi0.imem_addr, expAddr);
    end
    e.word = expAddr ^ PATTERN;
    e.addr = expAddr;
    sb.push_back(e);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("valid_after_ack", {31'h0, bi0.instr_valid}, 32'h1);
    checkOutput("req_drop_after_ack", {31'h0, bi0.imem_req}, 32'h0);
  endtask

  task automatic checkPresent();
    checkOutput("sb_depth", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      checkOutput("instr", bi0.instr, sb[0].word);
      checkOutput("instr_pc", bi0.instr_pc, sb[0].addr);
    end
    checkOutput("instr_valid", {31'h0, bi0.instr_valid}, 32'h1);
  endtask

  // Hold ready low for stall cycles, then hand the word to the decoder.
  task automatic consume(input int stall);
    for (int i = 0; i < stall; i++) begin
      checkPresent();
      checkOutput("no_req_in_hold", {31'h0, bi0.imem_req}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    end
    checkPresent();
    if (sb.size() > 0) void'(sb.pop_front());
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expCount++;
    checkOutput("valid_after_hs", {31'h0, bi0.instr_valid}, 32'h0);
    checkOutput("fetch_count", {16'h0, fetchCount0}, {16'h0, expCount[15:0]});
  endtask

  task automatic checkResetState0();
    checkOutput("rst_req", {31'h0, bi0.imem_req}, 32'h0);
    checkOutput("rst_addr", bi0.imem_addr, 32'h0);
    checkOutput("rst_valid", {31'h0, bi0.instr_valid}, 32'h0);
    checkOutput("rst_instr", bi0.instr, 32'h0);
    checkOutput("rst_instr_pc", bi0.instr_pc, 32'h0);
    checkOutput("rst_count", {16'h0, fetchCount0}, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expCount = 0;
    reset0   = 1'b1;
    reset1   = 1'b1;
    bi0.imem_ack = 1'b0; bi0.imem_rdata = 32'h0; bi0.instr_ready = 1'b0;
    bi0.redirect_valid = 1'b0; bi0.redirect_pc = 32'h0;
    bi1.imem_ack = 1'b0; bi1.imem_rdata = 32'h0; bi1.instr_ready = 1'b0;
    bi1.redirect_valid = 1'b0; bi1.redirect_pc = 32'h0;
    tick();
    tick();
    $display("[TB] reset state");
    checkResetState0();
    reset0 = 1'b0;
    tick();

    $display("[TB] zero-wait sequential fetch");
    for (int i = 0; i < 3; i++) begin
      serveFetch(0, 32'h0040_0000 + 32'(4 * i));
      consume(0);
    end
    checkOutput("count_after_three", {16'h0, fetchCount0}, 32'd3);

    $display("[TB] slow memory and stalled decoder");
    serveFetch(3, 32'h0040_000C);
    consume(4);

    $display("[TB] redirect in HOLD with ready");
    serveFetch(0, 32'h0040_0010);
    checkPresent();
    applyStimulus(1'b0, 1'b1, 32'h0000_1003, 1'b1);
    void'(sb.pop_front());
    checkOutput("hold_redir_valid", {31'h0, bi0.instr_valid}, 32'h0);
    checkOutput("hold_redir_count", {16'h0, fetchCount0}, 32'd4);
    checkOutput("hold_redir_req", {31'h0, bi0.imem_req}, 32'h1);
    checkOutput("hold_redir_addr", bi0.imem_addr, 32'h0000_1000);
    serveFetch(0, 32'h0000_1000);
    consume(0);

    $display("[TB] redirect with ack, then redirects while pending");
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 1'b0);
    checkOutput("ackredir_valid", {31'h0, bi0.instr_valid}, 32'h0);
    checkOutput("ackredir_addr", bi0.imem_addr, 32'h0000_0010);
    applyStimulus(1'b0, 1'b1, 32'h0000_2000, 1'b0);
    checkOutput("discard_req", {31'h0, bi0.imem_req}, 32'h1);
    checkOutput("discard_addr", bi0.imem_addr, 32'h0000_0010);
    applyStimulus(1'b0, 1'b1, 32'h0000_3000, 1'b0);
    checkOutput("discard_addr2", bi0.imem_addr, 32'h0000_0010);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("discard_dropped", {31'h0, bi0.instr_valid}, 32'h0);
    checkOutput("after_discard_addr", bi0.imem_addr, 32'h0000_3000);
    serveFetch(0, 32'h0000_3000);
    consume(0);

    $display("[TB] reset while in DISCARD");
    applyStimulus(1'b0, 1'b1, 32'h0000_4000, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    reset0 = 1'b1;
    tick();
    checkResetState0();
    reset0   = 1'b0;
    expCount = 0;
    tick();
    checkOutput("post_reset_req", {31'h0, bi0.imem_req}, 32'h1);
    serveFetch(1, 32'h0040_0000);
    consume(0);

    $display("[TB] top-of-memory start: redirect with ack");
    reset1 = 1'b0;
    tick();
    checkOutput("u1_first_addr", bi1.imem_addr, 32'hFFFF_FFFC);
    bi1.imem_ack = 1'b1; bi1.imem_rdata = 32'h1234_5678;
    bi1.redirect_valid = 1'b1; bi1.redirect_pc = 32'h0000_0500;
    tick();
    bi1.imem_ack = 1'b0; bi1.redirect_valid = 1'b0;
    checkOutput("u1_drop_valid", {31'h0, bi1.instr_valid}, 32'h0);
    checkOutput("u1_redir_req", {31'h0, bi1.imem_req}, 32'h1);
    checkOutput("u1_redir_addr", bi1.imem_addr, 32'h0000_0500);

    $display("[TB] PC wrap");
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    tick();
    checkOutput("u1_wrap_first", bi1.imem_addr, 32'hFFFF_FFFC);
    bi1.imem_ack = 1'b1; bi1.imem_rdata = 32'hFFFF_FFFC ^ PATTERN;
    tick();
    bi1.imem_ack = 1'b0;
    checkOutput("u1_instr", bi1.instr, 32'hFFFF_FFFC ^ PATTERN);
    checkOutput("u1_instr_pc", bi1.instr_pc, 32'hFFFF_FFFC);
    bi1.instr_ready = 1'b1;
    tick();
    bi1.instr_ready = 1'b0;
    checkOutput("u1_wrap_req", {31'h0, bi1.imem_req}, 32'h1);
    checkOutput("u1_wrap_addr", bi1.imem_addr, 32'h0000_0000);
    checkOutput("u1_count", {16'h0, fetchCount1}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-issue MIPS core: holds the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents each word to the instruction decoder/control stage over a valid/ready handshake. It is the producer end of the decoder's `instruction` input. It also accepts PC redirects, which come from branch/jump resolution.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, synchronous, active-high.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: word-aligned fetch address.
- `imem_ack` input 1: single-cycle completion pulse; meaningful only while `imem_req`=1.
- `imem_rdata` input 32: fetched word, valid in the `imem_ack` cycle.
- `instr_valid` output 1: `instr`/`instr_pc` hold an unconsumed instruction.
- `instr_ready` input 1: decoder accepts the instruction this cycle.
- `instr` output 32: instruction word to the decoder.
- `instr_pc` output 32: address of `instr`.
- `redirect_valid` input 1: single-cycle PC redirect (taken branch, jump).
- `redirect_pc` input 32: redirect target; bits [1:0] ignored (forced 0).
- `fetch_count` output 16: count of instructions accepted by the decoder; wraps.

## Operation
- State machine states: FETCH, HOLD, DISCARD. All outputs are registered.
- Reset (cycle with `reset`=1): state FETCH, `pc`=RESET_PC, `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fetch_count`=0. Reset overrides everything, including a request in flight.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until `imem_ack`.
  - On ack without redirect: `instr`<=`imem_rdata`, `instr_pc`<=`pc`, `instr_valid`<=1, `pc`<=`pc`+4, `imem_req`<=0, go to HOLD.
- HOLD:
  - `instr`, `instr_pc` and `instr_valid` stay stable until the handshake.
  - On `instr_valid`&`instr_ready` without redirect: `instr_valid`<=0, `fetch_count`+1, go to FETCH with `imem_req`<=1.
- Redirect (`redirect_valid`=1) has priority over every other event:
  - FETCH with `imem_ack`=1 in the same cycle: drop the data, `pc`<=`{redirect_pc[31:2],2'b00}`, stay in FETCH with the new address next cycle.
  - FETCH without ack: `pc`<=target, go to DISCARD. `imem_req` and the old `imem_addr` stay held, because a request cannot be withdrawn.
  - HOLD: `instr_valid`<=0, `pc`<=target, go to FETCH. A simultaneous `instr_ready` is ignored: no handshake, and `fetch_count` does not change.
  - DISCARD: `pc`<=new target; the last redirect wins.
- DISCARD: `imem_req`=1 with the old address until `imem_ack`. The data is dropped, then go to FETCH at `pc`.
- Arithmetic:
  - `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC goes to 32'h0000_0000.
  - `fetch_count` wraps 16'hFFFF to 0.
- `imem_ack` while `imem_req`=0 is ignored.

## Timing
- Memory with zero wait states (ack in the first req cycle):
  - Req at cycle N, ack at N, `instr_valid` at N+1.
  - If ready is given at N+1, the next req is at N+2.
  - Peak throughput is one instruction per 2 cycles.
- With a wait of k cycles (ack at N+k), `instr_valid` rises at N+k+1.
- After a redirect in HOLD (cycle R): req to the target at R+1; the earliest valid is at R+2.
- After a redirect in FETCH without ack (cycle R): the old request completes at ack cycle A ≥ R+1, then req to the target at A+1.
- After a redirect coinciding with ack (cycle R): req to the target at R+1.
- `imem_addr` changes only on the cycle after an ack, or after a redirect that leaves the FETCH/HOLD states.

## Test plan
- Reset with RESET_PC=32'h0040_0000, zero-wait memory returning addr^32'hA5A5_A5A5, `instr_ready`=1 → `instr_pc` sequence 0x00400000, 0x00400004, 0x00400008, `instr` matches, `fetch_count`=3 after the third handshake.
- Memory ack delayed 3 cycles and `instr_ready` held 0 for 4 cycles in HOLD → `imem_addr` stable for the whole req, `instr`/`instr_pc` unchanged while stalled, no second req until the handshake.
- Redirect to 32'h0000_1003 while in HOLD with `instr_ready`=1 → `instr_valid` drops, `fetch_count` unchanged, next `imem_addr`=32'h0000_1000.
- Redirect to 0x2000 while a req to 0x10 is pending (ack 2 cycles later), then a second redirect to 0x3000 in DISCARD → the 0x10 data is never presented, next `imem_addr`=0x3000.
- Redirect coinciding with ack, and RESET_PC=32'hFFFF_FFFC → the acked data is dropped and the next address is the target; separately, the PC after the first fetch wraps to 0x00000000.
- Assert `reset` mid-wait in DISCARD → all outputs return to their reset values, and after reset is released a req is issued at RESET_PC.
